// File: rtl/hash_out_collector_pkg.sv
// Shared definitions for the hash output path: collector FSM encoding,
// the address-width helper used to size RAM ports, and the last-word mask.
// Pure definitions: no logic and no timing of its own.
package hash_out_collector_pkg;

   // Collector states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_FORCE   = 2'd2,
      ST_DONE    = 2'd3
   } hoc_state_t;

   // Ceiling log2, never less than 1 so that a port width is always legal.
   function automatic int clog2(input int unsigned n);
      int r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Last-word mask, one bit at a time: with rem = len mod width, bit
   // bit_idx of the final word survives only below rem. rem == 0 means
   // the final word is full, so every bit survives.
   function automatic logic last_word_keep(input int bit_idx, input int rem);
      return (rem == 0) || (bit_idx < rem);
   endfunction

endpackage

// File: rtl/hash_out_collector.sv
// Collects squeezed hash words into a RAM, masks the trailing partial word,
// then asks the hash core to stop squeezing and pulses o_done.
// Latency: a word accepted in cycle N is written in cycle N+1; one word/cycle.
// Backpressure: o_hash_data_ready is high only while collecting; excess
// words beyond the RAM depth are accepted and dropped.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_start             begin a collection (only honoured in IDLE)
//   i_output_length     requested length in bits, latched on i_start
//   i_hash_data(_valid) / o_hash_data_ready   word stream from the hash core
//   o_wr_en/addr/data   registered RAM write port
//   o_force_done / i_force_done_ack           stop-squeezing handshake
//   o_overflow          sticky: length exceeded RAM depth
//   o_busy, o_done      not-idle flag, one-cycle completion pulse
module hash_out_collector
   import hash_out_collector_pkg::*;
#(
   parameter int IO_WIDTH      = 32,
   parameter int MAX_RAM_DEPTH = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_start,
   input  logic [IO_WIDTH-1:0]              i_output_length,
   input  logic [IO_WIDTH-1:0]              i_hash_data,
   input  logic                             i_hash_data_valid,
   output logic                             o_hash_data_ready,
   output logic                             o_wr_en,
   output logic [clog2(MAX_RAM_DEPTH)-1:0]  o_wr_addr,
   output logic [IO_WIDTH-1:0]              o_wr_data,
   output logic                             o_force_done,
   input  logic                             i_force_done_ack,
   output logic                             o_overflow,
   output logic                             o_busy,
   output logic                             o_done
);

   localparam int AW = clog2(MAX_RAM_DEPTH);
   localparam logic [IO_WIDTH-1:0] WORD_BITS = IO_WIDTH'(IO_WIDTH);
   localparam logic [IO_WIDTH-1:0] DEPTH     = IO_WIDTH'(MAX_RAM_DEPTH);

   hoc_state_t          state_q;
   logic [IO_WIDTH-1:0] nwords_q;
   logic [IO_WIDTH-1:0] rem_q;
   logic [IO_WIDTH-1:0] cnt_q;
   logic                wr_en_q;
   logic [AW-1:0]       wr_addr_q;
   logic [IO_WIDTH-1:0] wr_data_q;
   logic                force_q;
   logic                ovf_q;
   logic                done_q;

   logic [IO_WIDTH-1:0] rem_d;
   logic [IO_WIDTH-1:0] nwords_d;
   logic [IO_WIDTH-1:0] wr_data_d;
   logic                handshake;
   logic                last_word;

   // Word count is len/width rounded up; done without an adder on len so a
   // length near the top of the range cannot wrap.
   assign rem_d    = i_output_length % WORD_BITS;
   assign nwords_d = (i_output_length / WORD_BITS)
                   + {{(IO_WIDTH-1){1'b0}}, (rem_d != '0)};

   assign handshake = i_hash_data_valid & o_hash_data_ready;
   assign last_word = (cnt_q == nwords_q - 1'b1);

   always_comb begin
      wr_data_d = '0;
      for (int b = 0; b < IO_WIDTH; b++) begin
         wr_data_d[b] = i_hash_data[b] & (~last_word | last_word_keep(b, int'(32'(rem_q))));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         nwords_q  <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         force_q   <= 1'b0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  nwords_q <= nwords_d;
                  rem_q    <= rem_d;
                  cnt_q    <= '0;
                  ovf_q    <= (nwords_d > DEPTH);
                  if (i_output_length == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_COLLECT;
                  end
               end
            end
            ST_COLLECT: begin
               if (handshake) begin
                  cnt_q <= cnt_q + 1'b1;
                  // Words past the RAM end are consumed but never written,
                  // so the address cannot wrap onto earlier data.
                  if (cnt_q < DEPTH) begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= cnt_q[AW-1:0];
                     wr_data_q <= wr_data_d;
                  end
                  if (last_word) begin
                     state_q <= ST_FORCE;
                     force_q <= 1'b1;
                  end
               end
            end
            ST_FORCE: begin
               if (i_force_done_ack) begin
                  state_q <= ST_DONE;
                  force_q <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are gated by rst so that the reset cycle itself is quiet,
   // including a write that was registered just before rst rose.
   assign o_hash_data_ready = (state_q == ST_COLLECT) & ~rst;
   assign o_busy            = (state_q != ST_IDLE) & ~rst;
   assign o_wr_en           = wr_en_q & ~rst;
   assign o_wr_addr         = rst ? '0 : wr_addr_q;
   assign o_wr_data         = rst ? '0 : wr_data_q;
   assign o_force_done      = force_q & ~rst;
   assign o_overflow        = ovf_q & ~rst;
   assign o_done            = done_q & ~rst;

endmodule
